// File: rtl/rf_pkg.sv
// Shared widths, op-codes, state encoding and capture record for the
// register-file op sequencer.
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        OP_MOV = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_LDI = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_EXEC  = 2'b10,
        ST_WRITE = 2'b11
    } state_e;

    // Fields of an accepted command that are still needed after READ.
    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] dst;
        logic [DATA_W-1:0] imm;
    } cap_t;

endpackage

// File: rtl/rf_op_sequencer_if.sv
// Command handshake plus register-file ports and status outputs of the
// sequencer, grouped as one bundle.
interface rf_op_sequencer_if;
    import rf_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_dst;
    logic [ADDR_W-1:0] cmd_srca;
    logic [ADDR_W-1:0] cmd_srcb;
    logic [DATA_W-1:0] cmd_imm;

    logic              we;
    logic [DATA_W-1:0] W;
    logic [ADDR_W-1:0] W_Addr;
    logic [ADDR_W-1:0] R_Addr;
    logic [ADDR_W-1:0] S_Addr;
    logic [DATA_W-1:0] R;
    logic [DATA_W-1:0] S;

    logic [DATA_W-1:0] result;
    logic              zero;
    logic              carry;
    logic              done;

    modport master (
        input  cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, R, S,
        output cmd_ready, we, W, W_Addr, R_Addr, S_Addr, result, zero, carry, done
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_dst, cmd_srca, cmd_srcb, cmd_imm, R, S,
        input  cmd_ready, we, W, W_Addr, R_Addr, S_Addr, result, zero, carry, done
    );

endinterface

// File: rtl/rf_alu16.sv
// Combinational 16-bit ALU; c is carry-out for ADD, borrow for SUB, else 0.
module rf_alu16
    import rf_pkg::*;
(
    input  op_e               op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    output logic [DATA_W-1:0] y_o,
    output logic              c_o
);

    logic [DATA_W:0] sum;

    always_comb begin
        y_o = '0;
        c_o = 1'b0;
        sum = {1'b0, a_i} + {1'b0, b_i};
        case (op_i)
            OP_MOV: y_o = a_i;
            OP_ADD: begin
                y_o = sum[DATA_W-1:0];
                c_o = sum[DATA_W];
            end
            OP_SUB: begin
                y_o = a_i - b_i;
                c_o = (a_i < b_i);
            end
            OP_AND: y_o = a_i & b_i;
            OP_OR:  y_o = a_i | b_i;
            OP_XOR: y_o = a_i ^ b_i;
            OP_LDI: y_o = imm_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/rf_op_sequencer.sv
// IDLE -> READ -> EXEC -> WRITE sequencer driving the register file's R/S read
// ports and W write port, one command per pass.
module rf_op_sequencer
    import rf_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    rf_op_sequencer_if.master bus
);

    state_e            state_q, state_d;
    cap_t              cap_q;
    logic [ADDR_W-1:0] raddr_q, saddr_q, waddr_q;
    logic [DATA_W-1:0] opa_q, opb_q, result_q, w_q;
    logic              zero_q, carry_q;
    logic [DATA_W-1:0] alu_y;
    logic              alu_c;

    rf_alu16 u_alu (
        .op_i  (cap_q.op),
        .a_i   (opa_q),
        .b_i   (opb_q),
        .imm_i (cap_q.imm),
        .y_o   (alu_y),
        .c_o   (alu_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // we/done decode straight from state so reset drops them immediately.
    always_comb begin
        state_d       = state_q;
        bus.cmd_ready = 1'b0;
        bus.we        = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) state_d = ST_READ;
            end
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WRITE;
            ST_WRITE: begin
                bus.we   = (cap_q.op != OP_NOP);
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q    <= '0;
            raddr_q  <= '0;
            saddr_q  <= '0;
            waddr_q  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            w_q      <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cap_q.op  <= op_e'(bus.cmd_op);
                        cap_q.dst <= bus.cmd_dst;
                        cap_q.imm <= bus.cmd_imm;
                        raddr_q   <= bus.cmd_srca;
                        saddr_q   <= bus.cmd_srcb;
                    end
                end
                ST_READ: begin
                    opa_q <= bus.R;
                    opb_q <= bus.S;
                end
                ST_EXEC: begin
                    waddr_q <= cap_q.dst;
                    // NOP leaves result, flags and W (which mirrors result) untouched.
                    if (cap_q.op != OP_NOP) begin
                        result_q <= alu_y;
                        w_q      <= alu_y;
                        zero_q   <= (alu_y == '0);
                        carry_q  <= alu_c;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.R_Addr = raddr_q;
    assign bus.S_Addr = saddr_q;
    assign bus.W_Addr = waddr_q;
    assign bus.W      = w_q;
    assign bus.result = result_q;
    assign bus.zero   = zero_q;
    assign bus.carry  = carry_q;

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Directed + random bench for rf_op_sequencer with an attached register file
// and an arithmetic reference model of the command semantics.
module tb_rf_op_sequencer;
    import rf_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_op_sequencer_if bus ();

    rf_op_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file the sequencer drives: combinational read, write on edge.
    logic [15:0] rf [8] = '{default: 16'h0};
    assign bus.R = rf[bus.R_Addr];
    assign bus.S = rf[bus.S_Addr];
    always @(posedge clk) if (bus.we) rf[bus.W_Addr] <= bus.W;

    logic [15:0] ref_rf [8] = '{default: 16'h0};
    logic [15:0] m_result, m_w;
    logic        m_zero, m_carry;
    logic [2:0]  m_waddr, m_raddr, m_saddr;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_result = 16'h0; m_w = 16'h0; m_zero = 1'b0; m_carry = 1'b0;
        m_waddr = 3'd0; m_raddr = 3'd0; m_saddr = 3'd0;
    endtask

    task automatic model_exec(input logic [2:0] op, input logic [2:0] dst,
                              input logic [2:0] a, input logic [2:0] b,
                              input logic [15:0] imm);
        int av, bv, r;
        bit c;
        av = ref_rf[a];
        bv = ref_rf[b];
        c  = 1'b0;
        r  = 0;
        case (op)
            3'd0: r = av;
            3'd1: begin r = av + bv; c = (r > 65535); r = r % 65536; end
            3'd2: begin c = (av < bv); r = (av - bv + 65536) % 65536; end
            3'd3: r = av & bv;
            3'd4: r = av | bv;
            3'd5: r = av ^ bv;
            3'd6: r = imm;
            default: r = 0;
        endcase
        m_raddr = a;
        m_saddr = b;
        m_waddr = dst;
        if (op != 3'd7) begin
            ref_rf[dst] = r[15:0];
            m_result    = r[15:0];
            m_w         = r[15:0];
            m_zero      = (r == 0);
            m_carry     = c;
        end
    endtask

    task automatic reset_values_chk(input string p);
        chk({p, "_ready"},  bus.cmd_ready, 1);
        chk({p, "_we"},     bus.we, 0);
        chk({p, "_done"},   bus.done, 0);
        chk({p, "_W"},      bus.W, 0);
        chk({p, "_W_Addr"}, bus.W_Addr, 0);
        chk({p, "_R_Addr"}, bus.R_Addr, 0);
        chk({p, "_S_Addr"}, bus.S_Addr, 0);
        chk({p, "_result"}, bus.result, 0);
        chk({p, "_zero"},   bus.zero, 0);
        chk({p, "_carry"},  bus.carry, 0);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [2:0] dst,
                           input logic [2:0] a, input logic [2:0] b,
                           input logic [15:0] imm);
        int          we_n;
        logic        seen;
        logic [15:0] w_at;
        logic [2:0]  wa_at;
        @(negedge clk);
        chk("idle_ready", bus.cmd_ready, 1);
        bus.cmd_op = op; bus.cmd_dst = dst; bus.cmd_srca = a; bus.cmd_srcb = b;
        bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        model_exec(op, dst, a, b, imm);
        we_n = 0; seen = 1'b0; w_at = 16'h0; wa_at = 3'd0;
        for (int k = 0; k < 8 && !seen; k++) begin
            if (k > 0) @(negedge clk);
            chk("busy_ready", bus.cmd_ready, 0);
            if (bus.we) begin we_n++; w_at = bus.W; wa_at = bus.W_Addr; end
            if (bus.done) seen = 1'b1;
        end
        chk("done_seen", seen, 1);
        chk("we_pulses", we_n, (op == 3'd7) ? 0 : 1);
        if (op != 3'd7) begin
            chk("W_at_we", w_at, ref_rf[dst]);
            chk("W_Addr_at_we", wa_at, dst);
        end
        chk("result", bus.result, m_result);
        chk("zero", bus.zero, m_zero);
        chk("carry", bus.carry, m_carry);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("rf_dst", rf[dst], ref_rf[dst]);
        chk("R_Addr_hold", bus.R_Addr, m_raddr);
        chk("S_Addr_hold", bus.S_Addr, m_saddr);
        chk("W_hold", bus.W, m_w);
        chk("W_Addr_hold", bus.W_Addr, m_waddr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] saved;
        int          dn, wn;
        logic [2:0]  rop, rd, ra, rb;
        logic [15:0] rimm;

        bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_dst = 3'd0;
        bus.cmd_srca = 3'd0; bus.cmd_srcb = 3'd0; bus.cmd_imm = 16'h0;
        model_reset();
        #1;
        reset_values_chk("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // LDI then MOV
        run_cmd(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h1234);
        chk("ldi_W", bus.W, 16'h1234);
        run_cmd(OP_MOV, 3'd2, 3'd1, 3'd0, 16'h0);
        chk("mov_W", bus.W, 16'h1234);
        chk("mov_W_Addr", bus.W_Addr, 2);
        chk("mov_zero", bus.zero, 0);

        // ADD with carry-out
        run_cmd(OP_LDI, 3'd3, 3'd0, 3'd0, 16'hFFFF);
        run_cmd(OP_LDI, 3'd4, 3'd0, 3'd0, 16'h0001);
        run_cmd(OP_ADD, 3'd5, 3'd3, 3'd4, 16'h0);
        chk("add_W", bus.W, 16'h0000);
        chk("add_zero", bus.zero, 1);
        chk("add_carry", bus.carry, 1);

        // SUB with borrow
        run_cmd(OP_LDI, 3'd1, 3'd0, 3'd0, 16'h0005);
        run_cmd(OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0007);
        run_cmd(OP_SUB, 3'd6, 3'd1, 3'd2, 16'h0);
        chk("sub_W", bus.W, 16'hFFFE);
        chk("sub_carry", bus.carry, 1);
        chk("sub_zero", bus.zero, 0);

        // Handshake: cmd_valid held for 12 cycles with one fixed ADD
        run_cmd(OP_LDI, 3'd3, 3'd0, 3'd0, 16'h1111);
        @(negedge clk);
        bus.cmd_op = OP_ADD; bus.cmd_dst = 3'd5; bus.cmd_srca = 3'd3;
        bus.cmd_srcb = 3'd4; bus.cmd_imm = 16'h0; bus.cmd_valid = 1'b1;
        model_exec(OP_ADD, 3'd5, 3'd3, 3'd4, 16'h0);
        dn = 0; wn = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.done) begin
                dn++;
                chk("hs_ready_in_write", bus.cmd_ready, 0);
            end
            if (bus.we) begin
                wn++;
                chk("hs_W", bus.W, 16'h1112);
            end
            if (i == 11) bus.cmd_valid = 1'b0;
        end
        chk("hs_done_count", dn, 3);
        chk("hs_we_count", wn, 3);
        chk("hs_ready_end", bus.cmd_ready, 1);
        chk("hs_rf5", rf[5], ref_rf[5]);

        // NOP keeps result, then XOR with dst == both sources
        saved = bus.result;
        run_cmd(OP_NOP, 3'd2, 3'd1, 3'd1, 16'hAAAA);
        chk("nop_result_kept", bus.result, saved);
        run_cmd(OP_XOR, 3'd1, 3'd1, 3'd1, 16'h0);
        chk("xor_W", bus.W, 16'h0000);
        chk("xor_zero", bus.zero, 1);

        // Reset during EXEC of LDI r7
        run_cmd(OP_LDI, 3'd7, 3'd0, 3'd0, 16'h7777);
        @(negedge clk);
        bus.cmd_op = OP_LDI; bus.cmd_dst = 3'd7; bus.cmd_imm = 16'hBEEF;
        bus.cmd_srca = 3'd2; bus.cmd_srcb = 3'd3; bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset_values_chk("rst_mid");
        model_reset();
        dn = 0; wn = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 1) reset = 1'b0;
            if (bus.done) dn++;
            if (bus.we) wn++;
        end
        chk("rst_no_we", wn, 0);
        chk("rst_no_done", dn, 0);
        chk("rst_r7_kept", rf[7], ref_rf[7]);
        reset_values_chk("rst_after");

        // Random commands against the reference model
        for (int n = 0; n < 40; n++) begin
            rop  = 3'($urandom_range(0, 7));
            rd   = 3'($urandom_range(0, 7));
            ra   = 3'($urandom_range(0, 7));
            rb   = 3'($urandom_range(0, 7));
            rimm = 16'($urandom);
            run_cmd(rop, rd, ra, rb, rimm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
